// File: rtl/snake_body_arb.sv
// snake_body_arb: circular snake body-position store with one read port shared by the VGA and item readers.
// Optional item-reader starvation guard: define SNAKE_BODY_ARB_STARVE_EN.
module snake_body_arb #(
  parameter int XSIZE      = 48,
  parameter int YSIZE      = 64,
  parameter int MAX_SIZE   = 20,
  parameter int IDX_W      = 5,
  parameter int STARVE_LIM = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clear,
  input  logic             i_Push,
  input  logic [5:0]       i_Push_x,
  input  logic [5:0]       i_Push_y,
  input  logic             i_Pop,
  input  logic             i_Req_Vga,
  input  logic             i_Req_Itm,
  input  logic [IDX_W-1:0] i_Idx_Vga,
  input  logic [IDX_W-1:0] i_Idx_Itm,
  output logic             o_Gnt_Vga,
  output logic             o_Gnt_Itm,
  output logic [5:0]       o_Rd_x,
  output logic [5:0]       o_Rd_y,
  output logic             o_Rd_Vld_Vga,
  output logic             o_Rd_Vld_Itm,
  output logic             o_Rd_Oob,
  output logic [IDX_W:0]   o_Count
);
  localparam logic [5:0]       SENT_X  = 6'(XSIZE - 1);
  localparam logic [5:0]       SENT_Y  = 6'(YSIZE - 1);
  localparam logic [IDX_W:0]   MAX_C   = (IDX_W+1)'(MAX_SIZE);
  localparam logic [IDX_W:0]   ONE_C   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] WP_LAST = IDX_W'(MAX_SIZE - 1);
  localparam logic [IDX_W-1:0] WP_ONE  = IDX_W'(1);

  if (2**IDX_W < MAX_SIZE || STARVE_LIM < 1) begin : g_bad_cfg
    $error("snake_body_arb: IDX_W too small for MAX_SIZE, or STARVE_LIM < 1");
  end

  logic [5:0]       mem_x [MAX_SIZE];
  logic [5:0]       mem_y [MAX_SIZE];
  logic [IDX_W-1:0] wp;
  logic [IDX_W-1:0] wp_inc;
  logic [IDX_W:0]   count;
  logic             starve_force;
  logic             gnt_vga;
  logic             gnt_itm;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0]   rd_sum;
  logic [IDX_W-1:0] rd_phys;
  logic             rd_oob;

  always_comb begin
    gnt_vga = i_Req_Vga && !(i_Req_Itm && starve_force);
    gnt_itm = i_Req_Itm && (!i_Req_Vga || starve_force);
    rd_idx  = gnt_itm ? i_Idx_Itm : i_Idx_Vga;
    rd_oob  = ({1'b0, rd_idx} >= count) || ({1'b0, rd_idx} >= MAX_C);
    // logical index i -> physical (wp-1-i) mod MAX_SIZE; biased by MAX_SIZE so it never goes negative
    rd_sum  = {1'b0, wp} + MAX_C - ONE_C - {1'b0, rd_idx};
    rd_phys = (rd_sum >= MAX_C) ? IDX_W'(rd_sum - MAX_C) : IDX_W'(rd_sum);
    wp_inc  = (wp == WP_LAST) ? '0 : wp + WP_ONE;
  end

  assign o_Gnt_Vga = gnt_vga;
  assign o_Gnt_Itm = gnt_itm;
  assign o_Count   = count;

`ifdef SNAKE_BODY_ARB_STARVE_EN
  localparam int              SC_W   = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);
  logic [SC_W-1:0] starve_cnt;

  assign starve_force = (starve_cnt == SC_LIM);

  always_ff @(posedge i_Clk) begin
    if (i_Rst || gnt_itm || !(i_Req_Vga && i_Req_Itm)) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      wp    <= '0;
      count <= '0;
      mem_x <= '{default: SENT_X};
      mem_y <= '{default: SENT_Y};
    end else begin
      if (i_Push) begin
        mem_x[wp] <= i_Push_x;
        mem_y[wp] <= i_Push_y;
        wp        <= wp_inc;
      end
      // a pop paired with a push cancels it unless the buffer is empty
      if (i_Push && !(i_Pop && count != '0) && count != MAX_C) begin
        count <= count + ONE_C;
      end else if (!i_Push && i_Pop && count != '0) begin
        count <= count - ONE_C;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Rd_Vld_Vga <= 1'b0;
      o_Rd_Vld_Itm <= 1'b0;
      o_Rd_x       <= SENT_X;
      o_Rd_y       <= SENT_Y;
      o_Rd_Oob     <= 1'b0;
    end else begin
      o_Rd_Vld_Vga <= gnt_vga;
      o_Rd_Vld_Itm <= gnt_itm;
      if (gnt_vga || gnt_itm) begin
        o_Rd_Oob <= rd_oob;
        o_Rd_x   <= rd_oob ? SENT_X : mem_x[rd_phys];
        o_Rd_y   <= rd_oob ? SENT_Y : mem_y[rd_phys];
      end
    end
  end

endmodule
